// File: rtl/spmv_mem_arbiter_if.sv
// Requester, configuration, memory-port and status signals of spmv_mem_arbiter.
// slave = arbiter side, master = environment side.
interface spmv_mem_arbiter_if;
    logic        st_valid;
    logic [63:0] st_data;
    logic        st_ready;
    logic        cache_valid;
    logic [47:0] cache_addr;
    logic        cache_ready;
    logic        dec_valid;
    logic [47:0] dec_addr;
    logic [1:0]  dec_tag;
    logic        dec_ready;
    logic        cfg_load;
    logic [47:0] cfg_st_base;
    logic [47:0] cfg_st_end;
    logic        req_mem_ld;
    logic        req_mem_st;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic        req_mem_stall;
    logic        busy;
    logic        st_done;

    modport slave (
        input  st_valid, st_data, cache_valid, cache_addr, dec_valid, dec_addr, dec_tag,
               cfg_load, cfg_st_base, cfg_st_end, req_mem_stall,
        output st_ready, cache_ready, dec_ready, req_mem_ld, req_mem_st, req_mem_addr,
               req_mem_d_or_tag, busy, st_done
    );
    modport master (
        output st_valid, st_data, cache_valid, cache_addr, dec_valid, dec_addr, dec_tag,
               cfg_load, cfg_st_base, cfg_st_end, req_mem_stall,
        input  st_ready, cache_ready, dec_ready, req_mem_ld, req_mem_st, req_mem_addr,
               req_mem_d_or_tag, busy, st_done
    );
endinterface

// File: rtl/spmv_mem_arbiter.sv
// SpMV memory arbiter: store/cache/decoder requesters into a queued, stallable memory port.
// Define SPMV_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority S > C > D.
module spmv_mem_arbiter #(
    parameter int QDEPTH = 4,
    parameter int STRIDE = 8
) (
    input logic                clk,
    input logic                rst,
    spmv_mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic        ld;
        logic        st;
        logic [47:0] addr;
        logic [63:0] d;
    } entry_t;

    state_t        state_q, state_d;
    logic [47:0]   st_ptr_q, st_ptr_d, end_ptr_q, end_ptr_d;
    logic [1:0]    rr_q, rr_d;
    logic          stall_q, stall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          ld_q, ld_d, st_q, st_d, done_q, done_d;
    logic [47:0]   addr_q, addr_d;
    logic [63:0]   dat_q, dat_d;
    entry_t        q_mem [QDEPTH];

    logic [2:0] req, gnt;
    logic       st_live, push, pop;
    entry_t     ent;

    function automatic logic [2:0] prio(input logic [2:0] x);
        return {x[2] & ~x[1] & ~x[0], x[1] & ~x[0], x[0]};
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Grant threshold leaves room for the two pushes that can land before a stall is seen.
    always_comb begin
        req = '0;
        if (state_q != IDLE && cnt_q <= CW'(QDEPTH - 3))
            req = {bus.dec_valid, bus.cache_valid, bus.st_valid};
`ifdef SPMV_ARB_ROUND_ROBIN_EN
        // Rotate so rr_q is bit 0, pick lowest, rotate the grant back.
        case (rr_q)
            2'd1:    begin logic [2:0] p; p = prio({req[0], req[2], req[1]}); gnt = {p[1], p[0], p[2]}; end
            2'd2:    begin logic [2:0] p; p = prio({req[1], req[0], req[2]}); gnt = {p[0], p[2], p[1]}; end
            default: gnt = prio(req);
        endcase
`else
        gnt = prio(req);
`endif
        rr_d = rr_q;
        if (gnt[0]) rr_d = 2'd1;
        if (gnt[1]) rr_d = 2'd2;
        if (gnt[2]) rr_d = 2'd0;

        st_live = (st_ptr_q != end_ptr_q);
        push    = (gnt[0] & st_live) | gnt[1] | gnt[2];
        pop     = (cnt_q != '0) && !stall_q;

        ent = '{ld: 1'b1, st: 1'b0, addr: bus.dec_addr, d: {61'd0, bus.dec_tag, 1'b0}};
        if (gnt[0]) ent = '{ld: 1'b0, st: 1'b1, addr: st_ptr_q, d: bus.st_data};
        if (gnt[1]) ent = '{ld: 1'b1, st: 1'b0, addr: bus.cache_addr, d: 64'd1};

        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        wr_d    = push ? nxt(wr_q) : wr_q;
        rd_d    = pop ? nxt(rd_q) : rd_q;
        stall_d = bus.req_mem_stall;

        ld_d   = 1'b0;
        st_d   = 1'b0;
        addr_d = addr_q;
        dat_d  = dat_q;
        if (pop) begin
            ld_d   = q_mem[rd_q].ld;
            st_d   = q_mem[rd_q].st;
            addr_d = q_mem[rd_q].addr;
            dat_d  = q_mem[rd_q].d;
        end

        state_d   = state_q;
        st_ptr_d  = (gnt[0] && st_live) ? st_ptr_q + 48'(STRIDE) : st_ptr_q;
        end_ptr_d = end_ptr_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.cfg_load) begin
                st_ptr_d  = bus.cfg_st_base;
                end_ptr_d = bus.cfg_st_end;
                state_d   = RUN;
            end
            RUN: if (!st_live) state_d = DRAIN;
            DRAIN: if (cnt_q == '0 && !bus.st_valid && !bus.cache_valid && !bus.dec_valid
                       && !ld_q && !st_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            st_ptr_q  <= '0;
            end_ptr_q <= '0;
            rr_q      <= '0;
            stall_q   <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            addr_q    <= '0;
            dat_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            st_ptr_q  <= st_ptr_d;
            end_ptr_q <= end_ptr_d;
            rr_q      <= rr_d;
            stall_q   <= stall_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            ld_q      <= ld_d;
            st_q      <= st_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            done_q    <= done_d;
        end
    end

    // Storage needs no reset: only slots between rd and wr are ever read.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_q] <= ent;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) assert (!(push && !pop && cnt_q == CW'(QDEPTH)))
            else $error("spmv_mem_arbiter: push into full queue");
    end
`endif

    assign bus.st_ready         = gnt[0];
    assign bus.cache_ready      = gnt[1];
    assign bus.dec_ready        = gnt[2];
    assign bus.req_mem_ld       = ld_q;
    assign bus.req_mem_st       = st_q;
    assign bus.req_mem_addr     = addr_q;
    assign bus.req_mem_d_or_tag = dat_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.st_done          = done_q;
endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed bench for spmv_mem_arbiter: arbitration vector table plus store/load/stall/reset sequences.
module tb_spmv_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spmv_mem_arbiter_if b();
    spmv_mem_arbiter #(.QDEPTH(4), .STRIDE(8)) dut (.clk(clk), .rst(rst), .bus(b));

    typedef struct {
        logic        ld;
        logic        st;
        logic [47:0] addr;
        logic [63:0] d;
        int          cyc;
    } op_t;
    typedef struct {
        logic [2:0] vld;
        logic [2:0] rdy;
    } vec_t;

    op_t  log_q[$];
    vec_t tv[8];
    int   cyc = 0, done_cnt = 0, total = 0, bad = 0;
    int   lb, d0, x0, n;
    logic cr, dr;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (b.req_mem_ld || b.req_mem_st)
            log_q.push_back('{b.req_mem_ld, b.req_mem_st, b.req_mem_addr, b.req_mem_d_or_tag, cyc});
        if (b.st_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_op(input string nm, input int idx, input logic est,
                          input logic [47:0] ea, input logic [63:0] ed);
        total++;
        if (idx >= log_q.size()) begin
            bad++;
            $display("FAIL %s: op %0d never issued", nm, idx);
        end else if ({log_q[idx].ld, log_q[idx].st, log_q[idx].addr, log_q[idx].d} !== {~est, est, ea, ed}) begin
            bad++;
            $display("FAIL %s: got ld=%0b st=%0b addr=%0h d=%0h want ld=%0b st=%0b addr=%0h d=%0h", nm,
                     log_q[idx].ld, log_q[idx].st, log_q[idx].addr, log_q[idx].d, ~est, est, ea, ed);
        end
    endtask

    task automatic clr_in();
        b.st_valid = 0; b.st_data = '0; b.cache_valid = 0; b.cache_addr = '0;
        b.dec_valid = 0; b.dec_addr = '0; b.dec_tag = '0; b.cfg_load = 0;
        b.cfg_st_base = '0; b.cfg_st_end = '0; b.req_mem_stall = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        b.st_valid = 1; b.cache_valid = 1; b.dec_valid = 1;
        @(negedge clk);
        chk("rst_mem", {b.req_mem_ld, b.req_mem_st, b.req_mem_addr, b.req_mem_d_or_tag}, '0);
        chk("rst_rdy", {b.st_ready, b.cache_ready, b.dec_ready}, '0);
        chk("rst_stat", {b.busy, b.st_done}, '0);
        tick();
        rst = 1;
        @(negedge clk);
        chk("idle_rdy", {b.st_ready, b.cache_ready, b.dec_ready}, '0);
        tick();
        b.st_valid = 0; b.cache_valid = 0; b.dec_valid = 0;
    endtask

    task automatic cfg(input logic [47:0] base, input logic [47:0] e);
        b.cfg_load = 1; b.cfg_st_base = base; b.cfg_st_end = e;
        tick();
        b.cfg_load = 0;
    endtask

    task automatic do_store(input logic [63:0] d);
        int k = 0;
        b.st_valid = 1; b.st_data = d;
        @(negedge clk);
        while (!b.st_ready && k < 50) begin @(negedge clk); k++; end
        if (!b.st_ready) begin
            total++; bad++;
            $display("FAIL store_hs: st_ready never rose for data %0h", d);
        end
        tick();
        b.st_valid = 0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (b.busy && k < 200) begin tick(); k++; end
        chk(nm, b.busy, 1'b0);
    endtask

    initial begin
        clr_in();
        do_reset();

        // arbitration table: from reset, no transfers, so priority is S > C > D in both builds
        tv[0] = '{3'b000, 3'b000}; tv[1] = '{3'b001, 3'b001};
        tv[2] = '{3'b010, 3'b010}; tv[3] = '{3'b011, 3'b001};
        tv[4] = '{3'b100, 3'b100}; tv[5] = '{3'b101, 3'b001};
        tv[6] = '{3'b110, 3'b010}; tv[7] = '{3'b111, 3'b001};
        cfg(48'h0, 48'h100);
        for (int i = 0; i < 8; i++) begin
            {b.dec_valid, b.cache_valid, b.st_valid} = tv[i].vld;
            @(negedge clk);
            chk($sformatf("arb_vec%0d", i), {b.dec_ready, b.cache_ready, b.st_ready}, tv[i].rdy);
            #1;
            b.st_valid = 0; b.cache_valid = 0; b.dec_valid = 0;
            tick();
        end

        // store window of two slots, third store discarded
        do_reset();
        lb = log_q.size(); d0 = done_cnt;
        cfg(48'h1000, 48'h1010);
        chk("busy_run", b.busy, 1'b1);
        do_store(64'hD0); do_store(64'hD1); do_store(64'hD2);
        wait_idle("st_idle");
        repeat (2) tick();
        chk_op("st0", lb, 1, 48'h1000, 64'hD0);
        chk_op("st1", lb + 1, 1, 48'h1008, 64'hD1);
        chk("st_cnt", log_q.size() - lb, 2);
        chk("st_done1", done_cnt - d0, 1);

        // cache then decoder, both held
        do_reset();
        cfg(48'h0, 48'h100);
        lb = log_q.size();
        b.cache_valid = 1; b.cache_addr = 48'h2000;
        b.dec_valid = 1; b.dec_addr = 48'h3000; b.dec_tag = 2'd2;
        n = 0;
        while ((b.cache_valid || b.dec_valid) && n < 20) begin
            @(negedge clk); cr = b.cache_ready; dr = b.dec_ready;
            tick();
            if (cr) b.cache_valid = 0;
            if (dr) b.dec_valid = 0;
            n++;
        end
        chk("ld_hs", {b.cache_valid, b.dec_valid}, 2'b00);
        repeat (4) tick();
        chk_op("ld_cache", lb, 0, 48'h2000, 64'h1);
        chk_op("ld_dec", lb + 1, 0, 48'h3000, 64'h4);
        if (log_q.size() >= lb + 2) chk("ld_consec", log_q[lb + 1].cyc - log_q[lb].cyc, 1);

        // stall holds a two-entry queue; third request is refused until it drains
        do_reset();
        cfg(48'h0, 48'h100);
        lb = log_q.size();
        b.req_mem_stall = 1; b.cache_valid = 1; b.cache_addr = 48'h4000;
        x0 = cyc;
        @(negedge clk); chk("stall_rdy0", b.cache_ready, 1'b1); tick();
        b.cache_addr = 48'h4008;
        @(negedge clk); chk("stall_rdy1", b.cache_ready, 1'b1); tick();
        b.cache_addr = 48'h4010;
        @(negedge clk); chk("stall_full2", b.cache_ready, 1'b0); tick();
        @(negedge clk); chk("stall_full3", b.cache_ready, 1'b0); tick();
        @(negedge clk); tick();
        b.req_mem_stall = 0;
        n = 0;
        @(negedge clk);
        while (!b.cache_ready && n < 30) begin @(negedge clk); n++; end
        chk("stall_c_hs", b.cache_ready, 1'b1);
        tick();
        b.cache_valid = 0;
        repeat (6) tick();
        if (log_q.size() > lb) chk("stall_window", log_q[lb].cyc > x0 + 5, 1'b1);
        chk_op("stall_a", lb, 0, 48'h4000, 64'h1);
        chk_op("stall_b", lb + 1, 0, 48'h4008, 64'h1);
        chk_op("stall_c", lb + 2, 0, 48'h4010, 64'h1);

        // all three requesters continuously valid
        do_reset();
        d0 = done_cnt;
`ifdef SPMV_ARB_ROUND_ROBIN_EN
        cfg(48'h0, 48'h10);
`else
        cfg(48'h0, 48'h18);
`endif
        lb = log_q.size();
        b.st_valid = 1; b.st_data = 64'hABCD;
        b.cache_valid = 1; b.cache_addr = 48'h2000;
        b.dec_valid = 1; b.dec_addr = 48'h3000; b.dec_tag = 2'd1;
        repeat (12) tick();
        b.st_valid = 0; b.cache_valid = 0; b.dec_valid = 0;
        wait_idle("all_idle");
        repeat (2) tick();
`ifdef SPMV_ARB_ROUND_ROBIN_EN
        chk_op("rr0", lb, 1, 48'h0, 64'hABCD);
        chk_op("rr1", lb + 1, 0, 48'h2000, 64'h1);
        chk_op("rr2", lb + 2, 0, 48'h3000, 64'h2);
        chk_op("rr3", lb + 3, 1, 48'h8, 64'hABCD);
        chk_op("rr4", lb + 4, 0, 48'h2000, 64'h1);
        chk_op("rr5", lb + 5, 0, 48'h3000, 64'h2);
`else
        chk_op("fp0", lb, 1, 48'h0, 64'hABCD);
        chk_op("fp1", lb + 1, 1, 48'h8, 64'hABCD);
        chk_op("fp2", lb + 2, 1, 48'h10, 64'hABCD);
        chk("fp_cnt", log_q.size() - lb, 3);
`endif
        chk("all_done", done_cnt - d0, 1);

        // base == end at load: straight to drain, store discarded
        do_reset();
        lb = log_q.size(); d0 = done_cnt;
        cfg(48'h500, 48'h500);
        do_store(64'h77);
        wait_idle("eq_idle");
        repeat (2) tick();
        chk("eq_cnt", log_q.size() - lb, 0);
        chk("eq_done", done_cnt - d0, 1);

        // store pointer wraps modulo 2^48
        do_reset();
        lb = log_q.size();
        cfg(48'hFFFF_FFFF_FFF8, 48'h8);
        do_store(64'h1); do_store(64'h2); do_store(64'h3);
        wait_idle("wrap_idle");
        repeat (2) tick();
        chk_op("wrap0", lb, 1, 48'hFFFF_FFFF_FFF8, 64'h1);
        chk_op("wrap1", lb + 1, 1, 48'h0, 64'h2);
        chk("wrap_cnt", log_q.size() - lb, 2);

        // reset with two queued entries drops them
        do_reset();
        cfg(48'h6000, 48'h7000);
        lb = log_q.size();
        b.req_mem_stall = 1; b.cache_valid = 1; b.cache_addr = 48'h5000;
        @(negedge clk); chk("rq_rdy0", b.cache_ready, 1'b1); tick();
        b.cache_addr = 48'h5008;
        @(negedge clk); chk("rq_rdy1", b.cache_ready, 1'b1); tick();
        b.cache_valid = 0;
        rst = 0; b.req_mem_stall = 0;
        tick();
        chk("rq_busy", b.busy, 1'b0);
        chk("rq_mem", {b.req_mem_ld, b.req_mem_st}, 2'b00);
        rst = 1;
        repeat (8) tick();
        chk("rq_dropped", log_q.size() - lb, 0);
        cfg(48'h6000, 48'h7000);
        chk("rq_cfg", b.busy, 1'b1);
        cfg(48'h9000, 48'h9100);
        do_store(64'h55);
        repeat (4) tick();
        chk_op("rq_store", lb, 1, 48'h6000, 64'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
